id_ex_reg: RTL and testbench
============================

Name: id_ex_reg

Overview:
- ID/EX pipeline register directly downstream of the immediate extender.
- Captures the decode-stage bundle (instruction, PC+8, register operands, extended immediate, control word, write-register address) and presents it to EX.
- Contains load-use hazard detection with one-cycle bubble insertion.
- Handles downstream EX stall and branch/exception flush, including a pending-flush flag and a saturating bubble counter.

Parameters:
- CTRL_W, 16, width of the decoded control word carried to EX.
- LOAD_BIT, 0, index in ctrl of the "instruction is a load" flag.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_instr  in  32  instruction word.
- id_pc8  in  32  PC+8 (link value).
- id_rs_data  in  32  rs operand.
- id_rt_data  in  32  rt operand.
- id_ext  in  32  extender output.
- id_ctrl  in  CTRL_W  decoded control.
- id_rs_addr  in  5  rs index.
- id_rt_addr  in  5  rt index.
- id_wa  in  5  destination register index.
- id_uses_rs  in  1  ID instruction reads rs in EX.
- id_uses_rt  in  1  ID instruction reads rt in EX.
- flush  in  1  kill the ID instruction (branch taken or exception).
- ex_stall  in  1  EX cannot accept (e.g. multiply/divide busy).
- ex_valid  out  1  EX slot holds a real instruction.
- ex_instr, ex_pc8, ex_rs_data, ex_rt_data, ex_ext  out  32 each  registered copies.
- ex_ctrl  out  CTRL_W  registered control.
- ex_wa  out  5  registered destination.
- stall_id  out  1  combinational; upstream PC and IF/ID must hold this cycle.
- flush_pend  out  1  registered; a flush arrived during ex_stall and is not yet applied.
- bubble_cnt  out  CNT_W  bubbles inserted since reset.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - All ex_* outputs = 0 and ex_valid = 0.
  - flush_pend = 0, bubble_cnt = 0.
  - stall_id evaluates to 0 while in reset.
- Bubble definition: ex_valid=0, ex_instr=0, ex_ctrl=0, ex_wa=0. The data fields ex_pc8, ex_rs_data, ex_rt_data, ex_ext are also 0.
- Load-use hazard, combinational:
  - hz = ex_valid & ex_ctrl[LOAD_BIT] & ex_wa!=0 & id_valid
    & ((id_uses_rs & id_rs_addr==ex_wa) | (id_uses_rt & id_rt_addr==ex_wa)).
- Per-edge action, evaluated in this priority order:
  1. ex_stall=1: EX register holds; stall_id=1. If flush=1, set flush_pend=1. No count.
  2. flush=1 or flush_pend=1: load bubble; flush_pend cleared; stall_id=0; count +1.
  3. hz=1: load bubble; stall_id=1; count +1.
  4. Otherwise: load the id_* bundle; ex_valid=id_valid; stall_id=0.
- stall_id is combinational: stall_id = ex_stall | (hz & ~flush & ~flush_pend).
- Latency:
  - The bundle appears on ex_* one cycle after capture.
  - A load-use hazard costs exactly one bubble. On the next cycle the load has left EX, hz=0, and the dependent instruction is captured.
- Boundary cases:
  - id_valid=0 never raises hz and is captured as a bubble. This is not counted; only cases 2 and 3 count.
  - Register 0 destination never creates a hazard.
  - Flush and hz together: flush wins; the killed instruction causes no stall.
  - Consecutive ex_stall cycles with repeated flush keep flush_pend=1; it is applied once.
- bubble_cnt saturates at all-ones and does not wrap.
- Reset asserted mid-stall or with flush_pend set clears everything immediately, without waiting for a clock edge.

Test Plan:
- Reset then pass-through: release rst_n, id_valid=1, id_instr=0x8C010004, id_ext=0x00000004 → next edge ex_instr=0x8C010004, ex_ext=0x00000004, ex_valid=1, stall_id=0.
- Load-use: EX holds a load with ex_wa=1; ID add with rs=1, id_uses_rs=1 → stall_id=1, next edge bubble (ex_valid=0) and bubble_cnt=1; following edge add captured, stall_id=0.
- No hazard for $0 or unused operand: EX load with ex_wa=0, or ID id_uses_rt=0 with rt match → stall_id=0, no bubble.
- Flush during stall: ex_stall=1 for 3 cycles, flush pulsed in cycle 1 → EX holds, flush_pend=1; first edge after ex_stall drops loads bubble, flush_pend=0, bubble_cnt +1.
- Flush beats hazard: hz and flush both 1 → stall_id=0, one bubble, bubble_cnt +1 only.
- Async reset and saturation: force bubble_cnt to 0xFFFE, insert 3 bubbles → count holds at 0xFFFF; drop rst_n between clock edges → all outputs 0 immediately.

Source files
------------

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with load-use bubble insertion, EX-stall hold,
// deferred flush handling and a saturating bubble counter.
module id_ex_reg #(
  parameter int CTRL_W   = 16,
  parameter int LOAD_BIT = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [31:0]       id_instr,
  input  logic [31:0]       id_pc8,
  input  logic [31:0]       id_rs_data,
  input  logic [31:0]       id_rt_data,
  input  logic [31:0]       id_ext,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [4:0]        id_rs_addr,
  input  logic [4:0]        id_rt_addr,
  input  logic [4:0]        id_wa,
  input  logic              id_uses_rs,
  input  logic              id_uses_rt,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              ex_valid,
  output logic [31:0]       ex_instr,
  output logic [31:0]       ex_pc8,
  output logic [31:0]       ex_rs_data,
  output logic [31:0]       ex_rt_data,
  output logic [31:0]       ex_ext,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [4:0]        ex_wa,
  output logic              stall_id,
  output logic              flush_pend,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic hz;
  logic kill;

  always_comb begin
    hz = ex_valid & ex_ctrl[LOAD_BIT] & (ex_wa != 5'd0) & id_valid &
         ((id_uses_rs & (id_rs_addr == ex_wa)) |
          (id_uses_rt & (id_rt_addr == ex_wa)));
    kill = flush | flush_pend;
    // Gated with rst_n so upstream never sees a stall while in reset.
    stall_id = rst_n & (ex_stall | (hz & ~kill));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid   <= 1'b0;
      ex_instr   <= '0;
      ex_pc8     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_ext     <= '0;
      ex_ctrl    <= '0;
      ex_wa      <= '0;
      flush_pend <= 1'b0;
      bubble_cnt <= '0;
    end else if (ex_stall) begin
      if (flush) flush_pend <= 1'b1;
    end else if (kill || hz) begin
      ex_valid   <= 1'b0;
      ex_instr   <= '0;
      ex_pc8     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_ext     <= '0;
      ex_ctrl    <= '0;
      ex_wa      <= '0;
      flush_pend <= 1'b0;
      if (bubble_cnt != '1) bubble_cnt <= bubble_cnt + 1'b1;
    end else if (id_valid) begin
      ex_valid   <= 1'b1;
      ex_instr   <= id_instr;
      ex_pc8     <= id_pc8;
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_ext     <= id_ext;
      ex_ctrl    <= id_ctrl;
      ex_wa      <= id_wa;
    end else begin
      // An empty ID slot is captured as an uncounted bubble.
      ex_valid   <= 1'b0;
      ex_instr   <= '0;
      ex_pc8     <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_ext     <= '0;
      ex_ctrl    <= '0;
      ex_wa      <= '0;
    end
  end

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed self-checking bench for id_ex_reg.
module tb_id_ex_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_instr, id_pc8, id_rs_data, id_rt_data, id_ext;
  logic [15:0] id_ctrl;
  logic [4:0]  id_rs_addr, id_rt_addr, id_wa;
  logic        id_uses_rs, id_uses_rt, flush, ex_stall;
  logic        ex_valid;
  logic [31:0] ex_instr, ex_pc8, ex_rs_data, ex_rt_data, ex_ext;
  logic [15:0] ex_ctrl;
  logic [4:0]  ex_wa;
  logic        stall_id, flush_pend;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_cnt = 16'd0;

  always #5 clk = ~clk;

  id_ex_reg #(.CTRL_W(16), .LOAD_BIT(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc8(id_pc8), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_ext(id_ext), .id_ctrl(id_ctrl), .id_rs_addr(id_rs_addr),
    .id_rt_addr(id_rt_addr), .id_wa(id_wa), .id_uses_rs(id_uses_rs),
    .id_uses_rt(id_uses_rt), .flush(flush), .ex_stall(ex_stall),
    .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc8(ex_pc8),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_ext(ex_ext),
    .ex_ctrl(ex_ctrl), .ex_wa(ex_wa), .stall_id(stall_id),
    .flush_pend(flush_pend), .bubble_cnt(bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [31:0] instr,
                          input logic [15:0] ctrl, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] wa,
                          input logic urs, input logic urt);
    id_valid = v; id_instr = instr; id_ctrl = ctrl;
    id_rs_addr = rs; id_rt_addr = rt; id_wa = wa;
    id_uses_rs = urs; id_uses_rt = urt;
    id_pc8 = instr + 32'd8; id_rs_data = 32'h1111_0000 | instr[15:0];
    id_rt_data = 32'h2222_0000; id_ext = {16'd0, instr[15:0]};
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; ex_stall = 1'b1;
    drive_id(1'b1, 32'hDEAD_BEEF, 16'h0001, 5'd1, 5'd1, 5'd1, 1'b1, 1'b1);
    step(); step();
    checks++; if ({ex_valid, ex_instr, ex_ctrl, ex_wa} !== 54'd0) begin
      failures++; $display("FAIL reset_ex got=%h exp=0", {ex_valid, ex_instr, ex_ctrl, ex_wa}); end
    checks++; if ({ex_pc8, ex_rs_data, ex_rt_data, ex_ext} !== 128'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", {ex_pc8, ex_rs_data, ex_rt_data, ex_ext}); end
    checks++; if ({flush_pend, bubble_cnt} !== 17'd0) begin
      failures++; $display("FAIL reset_cnt got=%h exp=0", {flush_pend, bubble_cnt}); end
    checks++; if (stall_id !== 1'b0) begin
      failures++; $display("FAIL reset_stall got=%b exp=0", stall_id); end
    ex_stall = 1'b0;
    #3 rst_n = 1'b1;
    #1;
  endtask

  task automatic test_passthrough();
    drive_id(1'b1, 32'h8C01_0004, 16'h0000, 5'd0, 5'd1, 5'd2, 1'b1, 1'b0);
    step();
    checks++; if (ex_instr !== 32'h8C01_0004) begin
      failures++; $display("FAIL pass_instr got=%h exp=8c010004", ex_instr); end
    checks++; if (ex_ext !== 32'h0000_0004) begin
      failures++; $display("FAIL pass_ext got=%h exp=00000004", ex_ext); end
    checks++; if ({ex_valid, stall_id, ex_wa} !== {1'b1, 1'b0, 5'd2}) begin
      failures++; $display("FAIL pass_ctl got=%b exp=1000010", {ex_valid, stall_id, ex_wa}); end
    checks++; if (ex_pc8 !== 32'h8C01_000C) begin
      failures++; $display("FAIL pass_pc8 got=%h exp=8c01000c", ex_pc8); end
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 32'h8C01_0000, 16'h0001, 5'd0, 5'd1, 5'd1, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 32'h0022_1820, 16'h0000, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    #1;
    checks++; if (stall_id !== 1'b1) begin
      failures++; $display("FAIL lu_stall got=%b exp=1", stall_id); end
    step(); exp_cnt = 16'd1;
    checks++; if ({ex_valid, ex_instr, ex_wa} !== 38'd0) begin
      failures++; $display("FAIL lu_bubble got=%h exp=0", {ex_valid, ex_instr, ex_wa}); end
    checks++; if (bubble_cnt !== exp_cnt) begin
      failures++; $display("FAIL lu_cnt got=%0d exp=%0d", bubble_cnt, exp_cnt); end
    checks++; if (stall_id !== 1'b0) begin
      failures++; $display("FAIL lu_release got=%b exp=0", stall_id); end
    step();
    checks++; if ({ex_valid, ex_instr} !== {1'b1, 32'h0022_1820}) begin
      failures++; $display("FAIL lu_capture got=%h exp=100221820", {ex_valid, ex_instr}); end
  endtask

  task automatic test_no_hazard();
    drive_id(1'b1, 32'h8C00_0010, 16'h0001, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 32'h0000_0020, 16'h0000, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1);
    #1;
    checks++; if (stall_id !== 1'b0) begin
      failures++; $display("FAIL nh_r0 got=%b exp=0", stall_id); end
    drive_id(1'b1, 32'h8C02_0010, 16'h0001, 5'd0, 5'd0, 5'd2, 1'b1, 1'b0);
    step();
    drive_id(1'b1, 32'h00A2_0020, 16'h0000, 5'd5, 5'd2, 5'd6, 1'b1, 1'b0);
    #1;
    checks++; if (stall_id !== 1'b0) begin
      failures++; $display("FAIL nh_unused_rt got=%b exp=0", stall_id); end
    drive_id(1'b0, 32'h0040_0020, 16'h0000, 5'd2, 5'd2, 5'd6, 1'b1, 1'b1);
    #1;
    checks++; if (stall_id !== 1'b0) begin
      failures++; $display("FAIL nh_invalid got=%b exp=0", stall_id); end
    step();
    checks++; if ({ex_valid, ex_instr, bubble_cnt} !== {1'b0, 32'd0, exp_cnt}) begin
      failures++; $display("FAIL nh_idle_bubble got=%h exp=%h", {ex_valid, ex_instr, bubble_cnt}, {33'd0, exp_cnt}); end
  endtask

  task automatic test_flush_stall();
    drive_id(1'b1, 32'h0123_4567, 16'h00F0, 5'd3, 5'd4, 5'd7, 1'b1, 1'b1);
    step();
    drive_id(1'b1, 32'h0BAD_0001, 16'h0000, 5'd0, 5'd0, 5'd8, 1'b0, 1'b0);
    ex_stall = 1'b1; flush = 1'b1;
    #1;
    checks++; if (stall_id !== 1'b1) begin
      failures++; $display("FAIL fs_stall got=%b exp=1", stall_id); end
    step(); flush = 1'b0;
    checks++; if ({flush_pend, ex_valid, ex_instr} !== {2'b11, 32'h0123_4567}) begin
      failures++; $display("FAIL fs_hold1 got=%h exp=301234567", {flush_pend, ex_valid, ex_instr}); end
    step(); flush = 1'b1;
    step(); flush = 1'b0; ex_stall = 1'b0;
    checks++; if ({flush_pend, ex_instr, bubble_cnt} !== {1'b1, 32'h0123_4567, exp_cnt}) begin
      failures++; $display("FAIL fs_hold3 got=%h exp=%h", {flush_pend, ex_instr, bubble_cnt}, {1'b1, 32'h0123_4567, exp_cnt}); end
    drive_id(1'b1, 32'h0000_5555, 16'h0000, 5'd0, 5'd0, 5'd9, 1'b0, 1'b0);
    #1;
    checks++; if (stall_id !== 1'b0) begin
      failures++; $display("FAIL fs_nostall got=%b exp=0", stall_id); end
    step(); exp_cnt = exp_cnt + 16'd1;
    checks++; if ({flush_pend, ex_valid, ex_instr, bubble_cnt} !== {2'b00, 32'd0, exp_cnt}) begin
      failures++; $display("FAIL fs_apply got=%h exp=%h", {flush_pend, ex_valid, ex_instr, bubble_cnt}, {34'd0, exp_cnt}); end
    step();
    checks++; if ({ex_valid, ex_instr, bubble_cnt} !== {1'b1, 32'h0000_5555, exp_cnt}) begin
      failures++; $display("FAIL fs_once got=%h exp=%h", {ex_valid, ex_instr, bubble_cnt}, {1'b1, 32'h0000_5555, exp_cnt}); end
  endtask

  task automatic test_flush_beats_hz();
    drive_id(1'b1, 32'h8C04_0000, 16'h0001, 5'd0, 5'd0, 5'd4, 1'b0, 1'b0);
    step();
    drive_id(1'b1, 32'h0084_2020, 16'h0000, 5'd4, 5'd0, 5'd4, 1'b1, 1'b0);
    flush = 1'b1;
    #1;
    checks++; if (stall_id !== 1'b0) begin
      failures++; $display("FAIL fh_stall got=%b exp=0", stall_id); end
    step(); flush = 1'b0; exp_cnt = exp_cnt + 16'd1;
    checks++; if ({ex_valid, bubble_cnt} !== {1'b0, exp_cnt}) begin
      failures++; $display("FAIL fh_bubble got=%h exp=%h", {ex_valid, bubble_cnt}, {1'b0, exp_cnt}); end
    drive_id(1'b1, 32'h0000_7777, 16'h0000, 5'd4, 5'd0, 5'd5, 1'b1, 1'b0);
    step();
    checks++; if ({ex_valid, ex_instr, bubble_cnt} !== {1'b1, 32'h0000_7777, exp_cnt}) begin
      failures++; $display("FAIL fh_next got=%h exp=%h", {ex_valid, ex_instr, bubble_cnt}, {1'b1, 32'h0000_7777, exp_cnt}); end
  endtask

  task automatic test_saturation_async_reset();
    int n;
    n = 32'hFFFE - int'(exp_cnt);
    flush = 1'b1;
    for (int i = 0; i < n; i++) step();
    checks++; if (bubble_cnt !== 16'hFFFE) begin
      failures++; $display("FAIL sat_fffe got=%h exp=fffe", bubble_cnt); end
    for (int i = 0; i < 3; i++) step();
    checks++; if (bubble_cnt !== 16'hFFFF) begin
      failures++; $display("FAIL sat_hold got=%h exp=ffff", bubble_cnt); end
    flush = 1'b0;
    drive_id(1'b1, 32'hCAFE_F00D, 16'h0003, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1);
    step();
    ex_stall = 1'b1; flush = 1'b1;
    step();
    checks++; if ({flush_pend, ex_instr} !== {1'b1, 32'hCAFE_F00D}) begin
      failures++; $display("FAIL ar_pre got=%h exp=1cafef00d", {flush_pend, ex_instr}); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({ex_valid, ex_instr, ex_ctrl, ex_wa, flush_pend, bubble_cnt, stall_id} !== 72'd0) begin
      failures++; $display("FAIL ar_clear got=%h exp=0", {ex_valid, ex_instr, ex_ctrl, ex_wa, flush_pend, bubble_cnt, stall_id}); end
    checks++; if ({ex_pc8, ex_rs_data, ex_rt_data, ex_ext} !== 128'd0) begin
      failures++; $display("FAIL ar_data got=%h exp=0", {ex_pc8, ex_rs_data, ex_rt_data, ex_ext}); end
    ex_stall = 1'b0; flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_load_use();
    test_no_hazard();
    test_flush_stall();
    test_flush_beats_hz();
    test_saturation_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
